// File: rtl/move_ctrl_if.sv
// move_ctrl_if: button, frame and collision inputs plus move/status outputs of move_ctrl
interface move_ctrl_if;
  logic i_btn, i_frame_tick, i_collision;
  logic o_move, o_btn_db, o_locked;
  logic [1:0] o_pending;
  modport master(output i_btn, i_frame_tick, i_collision, input o_move, o_btn_db, o_pending, o_locked);
  modport slave(input i_btn, i_frame_tick, i_collision, output o_move, o_btn_db, o_pending, o_locked);
endinterface

// File: rtl/move_ctrl.sv
// move_ctrl: debounces the hop button, queues hops, issues one move per frame, locks out after collisions
module move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18,
  parameter int MAX_PENDING = 3,
  parameter int LOCK_FRAMES = 30
) (
  input logic i_clk,
  input logic i_rst_n,
  move_ctrl_if.slave bus
);
  typedef enum logic {READY, LOCKED} state_t;
  state_t state, state_d;
  logic s1, s2, btn_db, move, move_d, press, issue;
  logic [CNT_W-1:0] cnt;
  logic [1:0] pending, pending_d;
  logic [5:0] lock_cnt, lock_d;
  // the press event is the same edge on which the debounced level flips to 1
  assign press = s2 && !btn_db && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      btn_db <= 1'b0;
    end else begin
      s1 <= bus.i_btn;
      s2 <= s1;
      if (s2 == btn_db) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= READY;
      lock_cnt <= '0;
      pending <= '0;
      move <= 1'b0;
    end else begin
      state <= state_d;
      lock_cnt <= lock_d;
      pending <= pending_d;
      move <= move_d;
    end
  end
  always_comb begin
    state_d = state;
    lock_d = lock_cnt;
    pending_d = pending;
    move_d = 1'b0;
    issue = 1'b0;
    if (state == READY) begin
      if (bus.i_collision) begin
        state_d = LOCKED;
        lock_d = 6'(LOCK_FRAMES);
        pending_d = '0;
      end else begin
        issue = bus.i_frame_tick && pending != 2'd0;
        move_d = issue;
        pending_d = (press && !issue) ? ((pending == 2'(MAX_PENDING)) ? pending : pending + 2'd1)
                  : (issue && !press) ? pending - 2'd1 : pending;
      end
    end else begin
      pending_d = '0;
      if (bus.i_collision) lock_d = 6'(LOCK_FRAMES);
      else if (bus.i_frame_tick && lock_cnt != 6'd0) begin
        lock_d = lock_cnt - 6'd1;
        state_d = (lock_cnt == 6'd1) ? READY : LOCKED;
      end
    end
  end
  assign bus.o_move = move;
  assign bus.o_btn_db = btn_db;
  assign bus.o_pending = pending;
  assign bus.o_locked = state == LOCKED;
endmodule
